// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation encodings, FSM states and result flags.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD               = 4'd0,
    SUB               = 4'd1,
    AND               = 4'd2,
    OR                = 4'd3,
    XOR               = 4'd4,
    SHIFT_LEFT        = 4'd5,
    SHIFT_RIGHT       = 4'd6,
    SHIFT_RIGHT_ARITH = 4'd7,
    MUL               = 4'd8,
    DIV               = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
    logic ovf;
    logic div_by_zero;
  } alu_flags_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Shared one-bit-per-cycle datapath for unsigned shift-add multiply and restoring divide.
// The first step is taken on the start edge, so done rises after exactly N steps.
module alu_muldiv_iter #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         is_div,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         done,
  output logic [N-1:0] lo,
  output logic [N-1:0] hi
);

  localparam int CW = $clog2(N + 1);

  logic [N-1:0]  lo_r;
  logic [N-1:0]  hi_r;
  logic [N-1:0]  b_r;
  logic          div_r;
  logic          active_r;
  logic [CW-1:0] cnt_r;

  // DIV: shift the next dividend bit into the remainder and subtract if it fits.
  // MUL: conditionally add the multiplicand to the high word, then shift right.
  function automatic logic [2*N-1:0] step(input logic d, input logic [N-1:0] h,
                                          input logic [N-1:0] l, input logic [N-1:0] dv);
    logic [N:0] t;
    if (d) begin
      t = {h, l[N-1]};
      if (t >= {1'b0, dv}) begin
        t = t - {1'b0, dv};
        return {t[N-1:0], l[N-2:0], 1'b1};
      end else begin
        return {t[N-1:0], l[N-2:0], 1'b0};
      end
    end else begin
      t = {1'b0, h} + (l[0] ? {1'b0, dv} : {(N+1){1'b0}});
      return {t, l[N-1:1]};
    end
  endfunction

  // Iteration state: load plus first step on start, then one step per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_r     <= {N{1'b0}};
      hi_r     <= {N{1'b0}};
      b_r      <= {N{1'b0}};
      div_r    <= 1'b0;
      active_r <= 1'b0;
      cnt_r    <= {CW{1'b0}};
    end else if (start) begin
      {hi_r, lo_r} <= step(is_div, {N{1'b0}}, a, b);
      b_r          <= b;
      div_r        <= is_div;
      active_r     <= 1'b1;
      cnt_r        <= CW'(1);
    end else if (active_r) begin
      if (cnt_r == CW'(N)) begin
        active_r <= 1'b0;
      end else begin
        {hi_r, lo_r} <= step(div_r, hi_r, lo_r, b_r);
        cnt_r        <= cnt_r + CW'(1);
      end
    end
  end

  assign done = active_r && (cnt_r == CW'(N));
  assign lo   = lo_r;
  assign hi   = hi_r;

endmodule

// File: rtl/seq_alu.sv
// Handshaked, registered N-bit ALU with single-cycle logic/arith/shift ops
// and N-cycle iterative unsigned multiply and divide.
module seq_alu
  import alu_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  alu_op_t      op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [N-1:0] result_hi,
  output logic         carry,
  output logic         zero,
  output logic         neg,
  output logic         ovf,
  output logic         div_by_zero,
  output logic         busy
);

  localparam int SHW = $clog2(N);

  alu_state_t   state_r;
  logic         alive_r;
  logic         out_valid_r;
  logic         busy_r;
  logic         is_div_r;
  logic [N-1:0] result_r;
  logic [N-1:0] result_hi_r;
  alu_flags_t   flags_r;

  logic         accept_s;
  logic         iter_op_s;
  logic         iter_done_s;
  logic [N-1:0] iter_lo_s;
  logic [N-1:0] iter_hi_s;
  logic [N-1:0] res_s;
  logic [N-1:0] res_hi_s;
  alu_flags_t   flags_s;
  logic [N:0]   ext_s;
  logic [SHW-1:0] sh_s;

  assign in_ready  = alive_r && ((state_r == IDLE) || ((state_r == DONE) && out_ready));
  assign accept_s  = in_valid && in_ready;
  assign iter_op_s = (op == MUL) || ((op == DIV) && (b != {N{1'b0}}));
  assign sh_s      = b[SHW-1:0];

  alu_muldiv_iter #(.N(N)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept_s && iter_op_s),
    .is_div (op == DIV),
    .a      (a),
    .b      (b),
    .done   (iter_done_s),
    .lo     (iter_lo_s),
    .hi     (iter_hi_s)
  );

  // Single-cycle results and flags, evaluated on the presented operands.
  always_comb begin
    res_s    = {N{1'b0}};
    res_hi_s = {N{1'b0}};
    flags_s  = '0;
    ext_s    = {(N+1){1'b0}};
    case (op)
      ADD: begin
        ext_s         = {1'b0, a} + {1'b0, b};
        res_s         = ext_s[N-1:0];
        flags_s.carry = ext_s[N];
        flags_s.ovf   = (a[N-1] == b[N-1]) && (ext_s[N-1] != a[N-1]);
      end
      SUB: begin
        ext_s         = {1'b0, a} - {1'b0, b};
        res_s         = ext_s[N-1:0];
        flags_s.carry = ext_s[N];
        flags_s.ovf   = (a[N-1] != b[N-1]) && (ext_s[N-1] != a[N-1]);
      end
      AND: res_s = a & b;
      OR:  res_s = a | b;
      XOR: res_s = a ^ b;
      SHIFT_LEFT: begin
        ext_s         = {1'b0, a} << sh_s;
        res_s         = ext_s[N-1:0];
        flags_s.carry = ext_s[N];
      end
      SHIFT_RIGHT: begin
        ext_s         = {a, 1'b0} >> sh_s;
        res_s         = ext_s[N:1];
        flags_s.carry = ext_s[0];
      end
      SHIFT_RIGHT_ARITH: begin
        ext_s         = $unsigned($signed({a, 1'b0}) >>> sh_s);
        res_s         = ext_s[N:1];
        flags_s.carry = ext_s[0];
      end
      DIV: begin
        res_s               = {N{1'b1}};
        res_hi_s            = a;
        flags_s.div_by_zero = 1'b1;
      end
      default: begin
        res_s = {N{1'b0}};
      end
    endcase
    flags_s.zero = (res_s == {N{1'b0}});
    flags_s.neg  = res_s[N-1];
  end

  // Control FSM with registered results; accept covers both IDLE and drain-and-reissue from DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      alive_r     <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      is_div_r    <= 1'b0;
      result_r    <= {N{1'b0}};
      result_hi_r <= {N{1'b0}};
      flags_r     <= '0;
    end else begin
      alive_r <= 1'b1;
      if (accept_s) begin
        is_div_r <= (op == DIV);
        if (iter_op_s) begin
          state_r     <= ITER;
          busy_r      <= 1'b1;
          out_valid_r <= 1'b0;
        end else begin
          state_r     <= DONE;
          out_valid_r <= 1'b1;
          result_r    <= res_s;
          result_hi_r <= res_hi_s;
          flags_r     <= flags_s;
        end
      end else begin
        case (state_r)
          IDLE: state_r <= IDLE;
          ITER: begin
            if (iter_done_s) begin
              state_r                 <= DONE;
              busy_r                  <= 1'b0;
              out_valid_r             <= 1'b1;
              result_r                <= iter_lo_s;
              result_hi_r             <= iter_hi_s;
              flags_r.carry           <= 1'b0;
              flags_r.zero            <= (iter_lo_s == {N{1'b0}});
              flags_r.neg             <= iter_lo_s[N-1];
              flags_r.ovf             <= !is_div_r && (iter_hi_s != {N{1'b0}});
              flags_r.div_by_zero     <= 1'b0;
            end
          end
          DONE: begin
            if (out_ready) begin
              state_r     <= IDLE;
              out_valid_r <= 1'b0;
            end
          end
          default: begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_valid   = out_valid_r;
  assign busy        = busy_r;
  assign result      = result_r;
  assign result_hi   = result_hi_r;
  assign carry       = flags_r.carry;
  assign zero        = flags_r.zero;
  assign neg         = flags_r.neg;
  assign ovf         = flags_r.ovf;
  assign div_by_zero = flags_r.div_by_zero;

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu at N=16 with hand-computed expected results.
module tb_seq_alu;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  alu_op_t     op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [15:0] result_hi;
  logic        carry, zero, neg, ovf, div_by_zero, busy;

  int errors = 0;
  int checks = 0;

  seq_alu #(.N(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .carry(carry), .zero(zero),
    .neg(neg), .ovf(ovf), .div_by_zero(div_by_zero), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // flags order: {carry, zero, neg, ovf, div_by_zero}
  task automatic do_op(input string tag, input alu_op_t o, input logic [15:0] va,
                       input logic [15:0] vb, input logic [15:0] er, input logic [15:0] eh,
                       input logic [4:0] ef, input int elat);
    int lat;
    a = va; b = vb; op = o; in_valid = 1'b1;
    #1;
    check({tag, ".in_ready"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF;
    lat = 1;
    while (!out_valid && lat < 40) begin
      check({tag, ".busy"}, busy, 1'b1);
      check({tag, ".in_ready_iter"}, in_ready, 1'b0);
      tick();
      lat++;
    end
    check({tag, ".latency"}, lat, elat);
    check({tag, ".result"}, result, er);
    check({tag, ".result_hi"}, result_hi, eh);
    check({tag, ".flags"}, {carry, zero, neg, ovf, div_by_zero}, ef);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = 16'h0000; b = 16'h0000; op = ADD;
    #12;
    check("rst.out_valid", out_valid, 1'b0);
    check("rst.busy", busy, 1'b0);
    check("rst.result", {result, result_hi}, 32'h0);
    check("rst.flags", {carry, zero, neg, ovf, div_by_zero}, 5'b00000);
    #5 rst_n = 1'b1;
    tick();
    check("rst.in_ready", in_ready, 1'b1);

    do_op("add_wrap", ADD, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 5'b11000, 1);
    do_op("sra", SHIFT_RIGHT_ARITH, 16'h8000, 16'h0004, 16'hF800, 16'h0000, 5'b00100, 1);
    do_op("sub_ovf", SUB, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 5'b00010, 1);
    do_op("sub_borrow", SUB, 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 5'b10100, 1);
    do_op("shl", SHIFT_LEFT, 16'h8001, 16'h0001, 16'h0002, 16'h0000, 5'b10000, 1);
    do_op("shr", SHIFT_RIGHT, 16'h0003, 16'h0001, 16'h0001, 16'h0000, 5'b10000, 1);
    do_op("shr0", SHIFT_RIGHT, 16'h0003, 16'h0010, 16'h0003, 16'h0000, 5'b00000, 1);
    do_op("xor", XOR, 16'hA5A5, 16'hFFFF, 16'h5A5A, 16'h0000, 5'b00000, 1);
    do_op("illegal", alu_op_t'(4'hF), 16'h0005, 16'h0003, 16'h0000, 16'h0000, 5'b01000, 1);
    do_op("mul", MUL, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 5'b00010, 17);
    do_op("div", DIV, 16'd100, 16'd7, 16'd14, 16'd2, 5'b00000, 17);
    do_op("div0", DIV, 16'h00AB, 16'h0000, 16'hFFFF, 16'h00AB, 5'b00101, 1);

    // Stall in DONE, then drain and reissue in the same cycle.
    out_ready = 1'b0;
    a = 16'hF0F0; b = 16'h0FF0; op = AND; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a = 16'(i); b = 16'h1111; op = SUB;
      check("stall.out_valid", out_valid, 1'b1);
      check("stall.result", {result, result_hi}, {16'h00F0, 16'h0000});
      check("stall.in_ready", in_ready, 1'b0);
      tick();
    end
    out_ready = 1'b1; in_valid = 1'b1; op = ADD; a = 16'h0002; b = 16'h0003;
    #1;
    check("reissue.in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check("reissue.out_valid", out_valid, 1'b1);
    check("reissue.result", result, 16'h0005);
    tick();
    check("reissue.drained", out_valid, 1'b0);

    // Reset in the middle of a multiply.
    a = 16'h1234; b = 16'h0100; op = MUL; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("midrst.busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst.out_valid", out_valid, 1'b0);
    check("midrst.busy", busy, 1'b0);
    #3 rst_n = 1'b1;
    tick();
    check("midrst.in_ready", in_ready, 1'b1);
    do_op("mul_small", MUL, 16'd3, 16'd5, 16'd15, 16'd0, 5'b00000, 17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
